exp5_unidade_controle: RTL and testbench

Moore control unit for the Experiment 5 sequence-memory game. It is the stage directly downstream of the datapath (exp5_fluxo_dados). It consumes the datapath's status signals (comparison, limit, end-of-count, play detection, timeout) and drives back every counter, register and timer enable. It also reports game outcome and current state for debug displays.

---
 rtl/exp5_unidade_controle_pkg.sv | 16 +
 rtl/exp5_unidade_controle.sv | 103 ++++++++++
 tb/tb_exp5_unidade_controle.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/exp5_unidade_controle_pkg.sv
// State codes for the Experiment 5 control unit, shared with the datapath display decoder.
package exp5_unidade_controle_pkg;

  localparam logic [3:0] INICIAL        = 4'b0000;
  localparam logic [3:0] PREPARACAO     = 4'b0001;
  localparam logic [3:0] NOVA_SEQUENCIA = 4'b0010;
  localparam logic [3:0] ESPERA_JOGADA  = 4'b0011;
  localparam logic [3:0] REGISTRA       = 4'b0100;
  localparam logic [3:0] COMPARACAO     = 4'b0101;
  localparam logic [3:0] PROXIMA_JOGADA = 4'b0110;
  localparam logic [3:0] PROXIMA_RODADA = 4'b0111;
  localparam logic [3:0] FIM_ACERTOU    = 4'b1010;
  localparam logic [3:0] FIM_ERROU      = 4'b1110;
  localparam logic [3:0] FIM_TIMEOUT    = 4'b1101;

endpackage

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the sequence-memory game: state register plus next-state/output decode.
module exp5_unidade_controle
  import exp5_unidade_controle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  input  logic       controle_timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  logic [3:0] estado;
  logic [3:0] proximo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo   = INICIAL;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    zeraT     = 1'b0;
    contaT    = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    unique case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; zeraT = 1'b1;
        proximo = NOVA_SEQUENCIA;
      end
      NOVA_SEQUENCIA: begin
        zeraE = 1'b1; zeraT = 1'b1;
        proximo = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        contaT = 1'b1;
        // A play arriving with the timeout wins.
        if (jogada_feita)          proximo = REGISTRA;
        else if (controle_timeout) proximo = FIM_TIMEOUT;
        else                       proximo = ESPERA_JOGADA;
      end
      REGISTRA: begin
        registraR = 1'b1;
        proximo   = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)                           proximo = FIM_ERROU;
        else if (enderecoIgualLimite && fimL) proximo = FIM_ACERTOU;
        else if (enderecoIgualLimite)         proximo = PROXIMA_RODADA;
        else                                  proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: begin
        contaE = 1'b1; zeraT = 1'b1;
        proximo = ESPERA_JOGADA;
      end
      PROXIMA_RODADA: begin
        contaL  = 1'b1;
        proximo = NOVA_SEQUENCIA;
      end
      FIM_ACERTOU: begin
        pronto = 1'b1; acertou = 1'b1;
        proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
      end
      FIM_ERROU: begin
        pronto = 1'b1; errou = 1'b1;
        proximo = iniciar ? PREPARACAO : FIM_ERROU;
      end
      FIM_TIMEOUT: begin
        pronto = 1'b1; timeout = 1'b1;
        proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
      default:        proximo = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Scoreboard bench for exp5_unidade_controle against a named-state game model.
module tb_exp5_unidade_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0;
  logic       enderecoIgualLimite = 1'b0, fimL = 1'b0, controle_timeout = 1'b0;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  exp5_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
    .controle_timeout(controle_timeout),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef enum {M_INI, M_PREP, M_NOVA, M_ESP, M_REG, M_CMP, M_PJ, M_PR,
                M_ACE, M_ERR, M_TO} ms_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_q[$];
  ms_t         ms = M_INI;

  // {code, zeraE,contaE,zeraL,contaL,zeraR,registraR,zeraT,contaT,pronto,acertou,errou,timeout}
  function automatic logic [15:0] expect_of(ms_t s);
    case (s)
      M_INI:  return {4'h0, 12'b0000_0000_0000};
      M_PREP: return {4'h1, 12'b1010_1010_0000};
      M_NOVA: return {4'h2, 12'b1000_0010_0000};
      M_ESP:  return {4'h3, 12'b0000_0001_0000};
      M_REG:  return {4'h4, 12'b0000_0100_0000};
      M_CMP:  return {4'h5, 12'b0000_0000_0000};
      M_PJ:   return {4'h6, 12'b0100_0010_0000};
      M_PR:   return {4'h7, 12'b0001_0000_0000};
      M_ACE:  return {4'hA, 12'b0000_0000_1100};
      M_ERR:  return {4'hE, 12'b0000_0000_1010};
      default: return {4'hD, 12'b0000_0000_1001};
    endcase
  endfunction

  function automatic ms_t next_of(ms_t s, logic ini, logic jf, logic ig, logic eil,
                                  logic fl, logic to);
    case (s)
      M_INI:  return ini ? M_PREP : M_INI;
      M_PREP: return M_NOVA;
      M_NOVA: return M_ESP;
      M_ESP:  return jf ? M_REG : (to ? M_TO : M_ESP);
      M_REG:  return M_CMP;
      M_CMP:  return !ig ? M_ERR : (eil ? (fl ? M_ACE : M_PR) : M_PJ);
      M_PJ:   return M_ESP;
      M_PR:   return M_NOVA;
      default: return ini ? M_PREP : s;
    endcase
  endfunction

  function automatic logic [15:0] actual();
    return {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
            pronto, acertou, errou, timeout};
  endfunction

  task automatic check(string name, logic [15:0] exp);
    logic [15:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected vector per clock, compared mid low phase.
  always @(negedge clock) begin
    if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
  end

  // Entered just after a negedge; returns just after the following negedge.
  task automatic step(logic ini, logic jf, logic ig, logic eil, logic fl, logic to);
    iniciar = ini; jogada_feita = jf; igual = ig;
    enderecoIgualLimite = eil; fimL = fl; controle_timeout = to;
    ms = next_of(ms, ini, jf, ig, eil, fl, to);
    exp_q.push_back(expect_of(ms));
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic start_game();
    step(1, 0, 0, 0, 0, 0);   // preparacao
    step(0, 0, 0, 0, 0, 0);   // nova_sequencia
    step(0, 0, 0, 0, 0, 0);   // espera_jogada
  endtask

  initial begin
    // Reset held across edges
    repeat (2) @(negedge clock);
    #1;
    check("reset_state", expect_of(M_INI));
    reset = 1'b1;

    repeat (10) step(0, 0, 1, 1, 1, 1);          // idle ignores everything but iniciar
    start_game();
    step(0, 1, 0, 0, 0, 0);                      // registra
    step(0, 0, 1, 1, 0, 0);                      // comparacao
    step(0, 0, 1, 1, 0, 0);                      // proxima_rodada
    step(0, 0, 1, 1, 0, 0);                      // nova_sequencia
    step(1, 0, 0, 0, 0, 0);                      // espera_jogada, iniciar ignored
    step(0, 1, 1, 0, 0, 0);                      // registra
    step(0, 0, 1, 0, 0, 0);                      // comparacao
    step(0, 0, 1, 0, 0, 0);                      // proxima_jogada
    step(0, 1, 1, 0, 0, 0);                      // espera_jogada
    step(0, 1, 1, 0, 0, 0);                      // registra
    step(0, 0, 0, 1, 1, 0);                      // comparacao
    step(0, 0, 0, 1, 1, 0);                      // fim_errou
    step(0, 0, 0, 0, 0, 0);                      // stays
    step(1, 0, 0, 0, 0, 0);                      // preparacao
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);                      // espera_jogada
    step(0, 0, 0, 0, 0, 1);                      // fim_timeout
    step(0, 0, 0, 0, 0, 1);
    start_game();
    step(0, 1, 0, 0, 0, 1);                      // collision -> registra
    step(0, 0, 1, 1, 1, 0);                      // comparacao
    step(0, 0, 1, 1, 1, 0);                      // fim_acertou
    step(0, 0, 1, 1, 1, 0);
    start_game();
    step(0, 0, 0, 0, 0, 0);                      // holding in espera_jogada

    // Asynchronous reset between edges
    reset = 1'b0;
    #1;
    check("async_reset", expect_of(M_INI));
    ms = M_INI;
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Randomized play with game-like biases
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(7) != 0,
           $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0);
      if ($urandom_range(499) == 0 && ms == M_ESP) begin
        reset = 1'b0;
        #1;
        check("async_reset_rand", expect_of(M_INI));
        ms = M_INI;
        #1;
        reset = 1'b1;
      end
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
